// File: rtl/alu_pkg.sv
// Shared ALU encodings: control codes, major opcodes and small helpers.
// The ALU itself and the issue controller both import this package.
package alu_pkg;

  // 4-bit ALU control codes; bit 3 selects subtract for the adder.
  typedef enum logic [3:0] {
    ALU_ADD = 4'b0000,
    ALU_SLL = 4'b0001,
    ALU_XOR = 4'b0100,
    ALU_SRL = 4'b0101,
    ALU_OR  = 4'b0110,
    ALU_AND = 4'b0111,
    ALU_SUB = 4'b1000
  } alu_ctrl_e;

  // Major opcodes handled by the execute stage.
  typedef enum logic [6:0] {
    OPC_OP     = 7'b0110011,
    OPC_OPIMM  = 7'b0010011,
    OPC_BRANCH = 7'b1100011
  } opcode_e;

  // BEQ (funct3[0]=0) is taken on zero, BNE (funct3[0]=1) on non-zero.
  function automatic logic br_resolve(input logic is_bne, input logic zero);
    return zero ^ is_bne;
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational decode of opcode/funct fields into ALU control,
// operand-B select, branch flag and illegal flag.
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output logic [3:0] ctrl,
  output logic       b_sel,
  output logic       is_branch,
  output logic       illegal
);

  alu_ctrl_e ctrl_sel;
  logic      arith;

  // Opcode class first, then funct3 for register/immediate arithmetic.
  always_comb begin
    ctrl_sel  = ALU_ADD;
    b_sel     = 1'b0;
    is_branch = 1'b0;
    illegal   = 1'b0;
    arith     = 1'b0;

    case (opcode)
      OPC_OP: arith = 1'b1;
      OPC_OPIMM: begin
        arith = 1'b1;
        b_sel = 1'b1;
      end
      OPC_BRANCH: begin
        is_branch = 1'b1;
        if (funct3[2:1] == 2'b00) begin
          ctrl_sel = ALU_SUB;
        end else begin
          illegal = 1'b1;
        end
      end
      default: illegal = 1'b1;
    endcase

    if (arith) begin
      case (funct3)
        3'b000: begin
          if ((opcode == OPC_OP) && funct7b5) begin
            ctrl_sel = ALU_SUB;
          end else begin
            ctrl_sel = ALU_ADD;
          end
        end
        3'b001: ctrl_sel = ALU_SLL;
        3'b100: ctrl_sel = ALU_XOR;
        3'b101: begin
          // Arithmetic right shift is not supported by the ALU.
          if (funct7b5) begin
            illegal = 1'b1;
          end else begin
            ctrl_sel = ALU_SRL;
          end
        end
        3'b110: ctrl_sel = ALU_OR;
        3'b111: ctrl_sel = ALU_AND;
        default: illegal = 1'b1;
      endcase
    end

    if (illegal) begin
      ctrl_sel = ALU_ADD;
    end
  end

  assign ctrl = ctrl_sel;

endmodule

// File: rtl/alu_issue_ctrl.sv
// Execute-stage issue/retire controller: accepts decoded instructions,
// drives the combinational ALU from the EX register and captures the
// result, branch outcome and illegal flag into the WB register.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [6:0]       opcode_i,
  input  logic [2:0]       funct3_i,
  input  logic             funct7b5_i,
  input  logic [XLEN-1:0]  rs1_data_i,
  input  logic [XLEN-1:0]  rs2_data_i,
  input  logic [XLEN-1:0]  imm_i,
  input  logic [XLEN-1:0]  pc_i,
  input  logic [4:0]       rd_i,
  input  logic             flush_i,
  input  logic             out_ready_i,
  output logic [XLEN-1:0]  alu_a_o,
  output logic [XLEN-1:0]  alu_b_o,
  output logic [3:0]       alu_ctrl_o,
  input  logic [XLEN-1:0]  alu_result_i,
  input  logic             alu_zero_i,
  output logic             wb_valid_o,
  output logic             wb_we_o,
  output logic [4:0]       wb_rd_o,
  output logic [XLEN-1:0]  wb_data_o,
  output logic             br_taken_o,
  output logic [XLEN-1:0]  br_target_o,
  output logic             illegal_o,
  output logic [CNT_W-1:0] retired_o,
  output logic [CNT_W-1:0] illegal_cnt_o
);

  logic [3:0]      dec_ctrl;
  logic            dec_b_sel;
  logic            dec_branch;
  logic            dec_illegal;

  logic            ex_valid;
  logic [XLEN-1:0] ex_a;
  logic [XLEN-1:0] ex_b;
  logic [3:0]      ex_ctrl;
  logic [4:0]      ex_rd;
  logic            ex_we;
  logic            ex_branch;
  logic            ex_bne;
  logic            ex_illegal;
  logic [XLEN-1:0] ex_target;

  logic            ex_adv;
  logic            ex_move;
  logic            accept;
  logic            retire;

  alu_op_decode u_dec (
    .opcode    (opcode_i),
    .funct3    (funct3_i),
    .funct7b5  (funct7b5_i),
    .ctrl      (dec_ctrl),
    .b_sel     (dec_b_sel),
    .is_branch (dec_branch),
    .illegal   (dec_illegal)
  );

  // Handshake terms; a flush in the same cycle as ex_adv suppresses the move.
  assign ex_adv     = ex_valid & (~wb_valid_o | out_ready_i);
  assign ex_move    = ex_adv & ~flush_i;
  assign in_ready_o = ~flush_i & (~ex_valid | ex_adv);
  assign accept     = in_valid_i & in_ready_o;
  assign retire     = wb_valid_o & out_ready_i;

  assign alu_a_o    = ex_a;
  assign alu_b_o    = ex_b;
  assign alu_ctrl_o = ex_ctrl;

  // EX register: load on accept, empty on flush or when its entry moves on.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid   <= 1'b0;
      ex_a       <= '0;
      ex_b       <= '0;
      ex_ctrl    <= '0;
      ex_rd      <= '0;
      ex_we      <= 1'b0;
      ex_branch  <= 1'b0;
      ex_bne     <= 1'b0;
      ex_illegal <= 1'b0;
      ex_target  <= '0;
    end else begin
      if (flush_i) begin
        ex_valid <= 1'b0;
      end else if (accept) begin
        ex_valid <= 1'b1;
      end else if (ex_adv) begin
        ex_valid <= 1'b0;
      end

      if (accept) begin
        ex_a       <= rs1_data_i;
        ex_b       <= dec_b_sel ? imm_i : rs2_data_i;
        ex_ctrl    <= dec_ctrl;
        ex_rd      <= rd_i;
        ex_we      <= ~dec_illegal & ~dec_branch & (rd_i != 5'd0);
        ex_branch  <= dec_branch;
        ex_bne     <= funct3_i[0];
        ex_illegal <= dec_illegal;
        ex_target  <= pc_i + imm_i;
      end
    end
  end

  // WB register: capture the ALU outcome when EX moves, hold while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid_o  <= 1'b0;
      wb_we_o     <= 1'b0;
      wb_rd_o     <= '0;
      wb_data_o   <= '0;
      br_taken_o  <= 1'b0;
      br_target_o <= '0;
      illegal_o   <= 1'b0;
    end else if (ex_move) begin
      wb_valid_o  <= 1'b1;
      wb_we_o     <= ex_we;
      wb_rd_o     <= ex_rd;
      wb_data_o   <= alu_result_i;
      br_taken_o  <= ex_branch & ~ex_illegal & br_resolve(ex_bne, alu_zero_i);
      br_target_o <= ex_target;
      illegal_o   <= ex_illegal;
    end else if (retire) begin
      wb_valid_o  <= 1'b0;
    end
  end

  // Saturating retire and illegal-retire counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      retired_o     <= '0;
      illegal_cnt_o <= '0;
    end else if (retire) begin
      if (retired_o != '1) begin
        retired_o <= retired_o + CNT_W'(1);
      end
      if (illegal_o && (illegal_cnt_o != '1)) begin
        illegal_cnt_o <= illegal_cnt_o + CNT_W'(1);
      end
    end
  end

endmodule
